cla_pipe_adder: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit CLA adder.
- Operand is split into NSEG segments of SEG_W bits. Each pipeline stage resolves one segment with grouped lookahead and registers the carry to the next stage.
- Valid/ready handshake on input and output, with backpressure.
- Sits in the datapath between operand-fetch and writeback wherever WIDTH exceeds single-cycle CLA timing.

---
 rtl/cla_pipe_pkg.sv | 33 +++
 rtl/cla_segment.sv | 56 +++++
 rtl/cla_pipe_adder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cla_pipe_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder.
// Saturation constants are only consumed when CLA_PIPE_SAT_EN is defined.
package cla_pipe_pkg;

  localparam int MAX_W = 1024;

  typedef struct packed {
    logic sub;
    logic signed_m;
    logic sat;
  } mode_t;

  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < width - 1; i++) begin
      r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-lookahead segment built from GROUP-wide lookahead groups.
// Also exposes the carry into the segment MSB for signed overflow detection.
module cla_segment
  import cla_pipe_pkg::*;
#(
  parameter int SEG_W = 8,
  parameter int GROUP = 4
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  localparam int NGRP = SEG_W / GROUP;

  logic [SEG_W-1:0] g_s;
  logic [SEG_W-1:0] p_s;

  assign g_s = a_i & b_i;
  assign p_s = a_i ^ b_i;

  // Group carries come from lookahead; bit carries are expanded from each group's carry-in.
  always_comb begin : carry_net
    logic [NGRP:0]  gc;
    logic [SEG_W:0] c;
    logic           gg;
    logic           gp;
    gc    = '0;
    c     = '0;
    gg    = 1'b0;
    gp    = 1'b1;
    gc[0] = cin_i;
    for (int j = 0; j < NGRP; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g_s[j*GROUP+i] | (p_s[j*GROUP+i] & gg);
        gp = gp & p_s[j*GROUP+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
    end
    for (int j = 0; j < NGRP; j++) begin
      c[j*GROUP] = gc[j];
      for (int i = 0; i < GROUP - 1; i++) begin
        c[j*GROUP+i+1] = g_s[j*GROUP+i] | (p_s[j*GROUP+i] & c[j*GROUP+i]);
      end
    end
    c[SEG_W] = gc[NGRP];
    sum_o    = p_s ^ c[SEG_W-1:0];
    cout_o   = c[SEG_W];
    cmsb_o   = c[SEG_W-1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: an input register then one SEG_W-bit segment per stage.
// Optional saturation on overflow is enabled by defining CLA_PIPE_SAT_EN.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

`ifdef CLA_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    mode_t            mode;
  } stage_t;

  stage_t           st_q [NSEG];
  stage_t           st_d [NSEG];
  logic [SEG_W-1:0] seg_sum  [NSEG];
  logic             seg_cout [NSEG];
  logic             seg_cmsb [NSEG];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;
  logic             advance_s;

  assign advance_s = out_ready | ~out_valid_q;
  assign in_ready  = advance_s;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    cla_segment #(
      .SEG_W (SEG_W),
      .GROUP (GROUP)
    ) u_seg (
      .a_i    (st_q[k].a[k*SEG_W +: SEG_W]),
      .b_i    (st_q[k].b[k*SEG_W +: SEG_W]),
      .cin_i  (st_q[k].carry),
      .sum_o  (seg_sum[k]),
      .cout_o (seg_cout[k]),
      .cmsb_o (seg_cmsb[k])
    );
  end

  // Input capture folds subtraction into inverted B with carry-in forced high.
  always_comb begin
    st_d[0].valid = in_valid;
    st_d[0].a     = in_a;
    st_d[0].b     = in_sub ? ~in_b : in_b;
    st_d[0].sum   = {WIDTH{1'b0}};
    st_d[0].carry = in_sub ? 1'b1 : in_cin;
    st_d[0].mode  = '{sub: in_sub, signed_m: in_signed, sat: in_sat};
    for (int k = 1; k < NSEG; k++) begin
      st_d[k]                           = st_q[k-1];
      st_d[k].sum[(k-1)*SEG_W +: SEG_W] = seg_sum[k-1];
      st_d[k].carry                     = seg_cout[k-1];
    end
  end

  // Last segment produces the flags and, when enabled, the clamped result.
  always_comb begin : last_stage
    logic [WIDTH-1:0] raw_sum;
    mode_t            mode_l;
    raw_sum                              = st_q[NSEG-1].sum;
    raw_sum[(NSEG-1)*SEG_W +: SEG_W]     = seg_sum[NSEG-1];
    mode_l                               = st_q[NSEG-1].mode;
    out_cout_d                           = seg_cout[NSEG-1];
    if (mode_l.signed_m) begin
      out_ovf_d = seg_cmsb[NSEG-1] ^ seg_cout[NSEG-1];
    end else if (mode_l.sub) begin
      out_ovf_d = ~seg_cout[NSEG-1];
    end else begin
      out_ovf_d = seg_cout[NSEG-1];
    end
    out_sum_d = raw_sum;
`ifdef CLA_PIPE_SAT_EN
    if (mode_l.sat && out_ovf_d) begin
      if (mode_l.signed_m) begin
        out_sum_d = st_q[NSEG-1].a[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end else if (mode_l.sub) begin
        out_sum_d = {WIDTH{1'b0}};
      end else begin
        out_sum_d = {WIDTH{1'b1}};
      end
    end else begin
      out_sum_d = raw_sum;
    end
`endif
    out_zero_d  = (out_sum_d == {WIDTH{1'b0}});
    out_valid_d = st_q[NSEG-1].valid;
  end

  // Whole pipeline advances together or holds; bubbles travel like ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        st_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_sum_q   <= {WIDTH{1'b0}};
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < NSEG; k++) begin
        st_q[k] <= st_d[k];
      end
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule
